// File: rtl/word_gen_scheduler.sv
// Round-robin scheduler that shares one word generator between NUM_REQ requesters.
// It grants a request, starts the generator, watches the output tap for eop, then waits out an idle gap.
module word_gen_scheduler #(
  parameter int NUM_REQ           = 4,
  parameter int WORD_COUNTER_SIZE = 8,
  parameter int GAP_WIDTH         = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req,
  input  logic [NUM_REQ*WORD_COUNTER_SIZE-1:0] req_len,
  output logic [NUM_REQ-1:0]                   req_ack,
  output logic [NUM_REQ-1:0]                   req_done,
  input  logic [GAP_WIDTH-1:0]                 gap_cycles,
  output logic                                 gen_msg_start,
  output logic [WORD_COUNTER_SIZE-1:0]         gen_msg_word_cnt,
  input  logic                                 mon_valid,
  input  logic                                 mon_ready,
  input  logic                                 mon_eop,
  output logic                                 busy,
  output logic [$clog2(NUM_REQ)-1:0]           active_id,
  output logic [15:0]                          msg_count
);
  localparam int IDW  = $clog2(NUM_REQ);
  localparam int IDW1 = IDW + 1;
  localparam int W    = WORD_COUNTER_SIZE;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_RUN   = 3'd2,
    S_GAP   = 3'd3,
    S_ZERO  = 3'd4
  } state_t;

  state_t               state_q;
  logic [IDW-1:0]       rr_q;
  logic [IDW-1:0]       id_q;
  logic [GAP_WIDTH-1:0] gap_cnt_q;
  logic [NUM_REQ-1:0]   req_ack_q;
  logic [NUM_REQ-1:0]   req_done_q;
  logic                 gen_start_q;
  logic [W-1:0]         word_cnt_q;
  logic                 busy_q;
  logic [15:0]          msg_count_q;

  logic                 win_found_s;
  logic [IDW-1:0]       win_id_s;
  logic [IDW-1:0]       win_next_s;
  logic [W-1:0]         win_len_s;
  logic [IDW1-1:0]      sum_s;
  logic [IDW1-1:0]      cand_s;
  logic                 hit_s;
  logic                 eop_hs_s;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDW-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Rotating priority search: first set req at or above the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    win_found_s = 1'b0;
    win_id_s    = '0;
    sum_s       = '0;
    cand_s      = '0;
    hit_s       = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_s       = {1'b0, rr_q} + IDW1'(k);
      cand_s      = (sum_s >= IDW1'(NUM_REQ)) ? (sum_s - IDW1'(NUM_REQ)) : sum_s;
      hit_s       = !win_found_s && req[cand_s[IDW-1:0]];
      win_id_s    = hit_s ? cand_s[IDW-1:0] : win_id_s;
      win_found_s = win_found_s | hit_s;
    end
  end

  assign win_len_s  = req_len[win_id_s*W +: W];
  assign win_next_s = (win_id_s == IDW'(NUM_REQ - 1)) ? '0 : (win_id_s + IDW'(1));
  assign eop_hs_s   = mon_valid & mon_ready & mon_eop;

  // Scheduler FSM; every output is a register written on the transition that makes it true.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      id_q        <= '0;
      gap_cnt_q   <= '0;
      req_ack_q   <= '0;
      req_done_q  <= '0;
      gen_start_q <= 1'b0;
      word_cnt_q  <= '0;
      busy_q      <= 1'b0;
      msg_count_q <= 16'd0;
    end else begin
      req_ack_q   <= '0;
      req_done_q  <= '0;
      gen_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (win_found_s) begin
            rr_q      <= win_next_s;
            id_q      <= win_id_s;
            req_ack_q <= onehot(win_id_s);
            busy_q    <= 1'b1;
            if (win_len_s != '0) begin
              state_q     <= S_START;
              gen_start_q <= 1'b1;
              word_cnt_q  <= win_len_s;
            end else begin
              // A zero count must never reach the generator: it would run a full 2^W words.
              state_q    <= S_ZERO;
              req_done_q <= onehot(win_id_s);
            end
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_START: begin
          state_q <= S_RUN;
          busy_q  <= 1'b1;
        end
        S_RUN: begin
          if (eop_hs_s) begin
            req_done_q  <= onehot(id_q);
            msg_count_q <= msg_count_q + 16'd1;
            if (gap_cycles == '0) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q   <= S_GAP;
              gap_cnt_q <= gap_cycles;
              busy_q    <= 1'b1;
            end
          end else begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
          end
        end
        S_GAP: begin
          if (gap_cnt_q <= GAP_WIDTH'(1)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q   <= S_GAP;
            gap_cnt_q <= gap_cnt_q - GAP_WIDTH'(1);
            busy_q    <= 1'b1;
          end
        end
        S_ZERO: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ack          = req_ack_q;
  assign req_done         = req_done_q;
  assign gen_msg_start    = gen_start_q;
  assign gen_msg_word_cnt = word_cnt_q;
  assign busy             = busy_q;
  assign active_id        = id_q;
  assign msg_count        = msg_count_q;

endmodule
